bin2bcd_seq: RTL
================

# bin2bcd_seq

Parametrised, multi-digit sequential binary-to-BCD converter built on the shift-and-add-3 (double-dabble) digit cell, generalised to DIGITS cascaded digits and a BIN_WIDTH-bit parallel operand. A start/done handshake makes it usable from display and UART formatting paths. Each request loads one operand and runs exactly BIN_WIDTH adjust-and-shift cycles. The block then presents a registered packed-BCD result, an overflow flag, and (optionally) a sign flag.

## Interface
- BIN_WIDTH, 16: operand width in bits; must be at least 2.
- DIGITS, 5: number of BCD output digits; must be at least 1.
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin_in  in  BIN_WIDTH  operand; sampled on the accepting edge only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse; result valid.
- bcd_out  out  4*DIGITS  packed BCD result; digit 0 is in bits [3:0]; holds its value until the next done.
- overflow  out  1  magnitude was at least 10^DIGITS; registered with bcd_out.
- sign  out  1  operand was negative; see Configuration.

## Operation
- FSM states: IDLE, SHIFT, FINISH. Reset state is IDLE.
- IDLE, start=1:
  - Load the shift register with the magnitude of bin_in.
  - Clear the working digits and the sticky overflow; set bit counter = 0.
  - Go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, one step per cycle:
  - Every working digit ≥5 gets +3 (4-bit result).
  - The whole chain then shifts left by 1. The shift-register MSB enters digit 0 bit 0. Each digit's bit 3 enters the next digit's bit 0.
  - The top digit's post-adjust bit 3 is shifted out and ORed into sticky overflow.
  - Counter increments. After the step with counter = BIN_WIDTH-1, go to FINISH.
- FINISH:
  - Copy the working digits to bcd_out and sticky overflow to overflow; update sign.
  - Pulse done; go to IDLE.
- A start arriving in SHIFT or FINISH is ignored and not queued.
- If DIGITS is too small, bcd_out holds the low DIGITS decimal digits of the magnitude and overflow=1.
- Digits never exceed 9 at FINISH.
- Reset (reset_n=0 at any edge, including mid-conversion):
  - State → IDLE.
  - busy=0, done=0, bcd_out=0, overflow=0, sign=0.
  - The working registers are cleared and the in-flight conversion is discarded with no done.

## Timing
- Call the start-accepting edge E0.
- Shifts happen on edges E1..E_BIN_WIDTH. FINISH is on edge E_(BIN_WIDTH+1).
- busy rises after E0 and falls after E_(BIN_WIDTH+1).
- done is high for exactly the cycle after E_(BIN_WIDTH+1). bcd_out, overflow and sign change on that same edge.
- Latency from start to done is BIN_WIDTH+1 cycles.
- In the done cycle the state is IDLE, so start may be asserted then. It is accepted on the following edge.
- Back-to-back throughput is one conversion per BIN_WIDTH+2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro BIN2BCD_SEQ_SIGNED_EN.
- Defined:
  - bin_in is two's complement. The loaded magnitude is -bin_in when bin_in[MSB]=1, else bin_in.
  - sign is bin_in[MSB] as captured at E0, presented with the result.
  - -2^(BIN_WIDTH-1) converts to magnitude 2^(BIN_WIDTH-1) without error.
- Undefined:
  - bin_in is unsigned, and sign is tied to 0.
  - No negation logic is synthesised.

## Test plan
- Unsigned, BIN_WIDTH=16, DIGITS=5: bin_in=65535 → done 17 cycles after the accepting edge, bcd_out=0x65535, overflow=0. bin_in=0 → bcd_out=0x00000, overflow=0.
- Overflow, DIGITS=4: bin_in=12345 → bcd_out=0x2345, overflow=1. Then bin_in=9999 → bcd_out=0x9999, overflow=0 (sticky flag cleared per conversion).
- Signed with BIN2BCD_SEQ_SIGNED_EN, BIN_WIDTH=16:
  - 0x8000 → sign=1, bcd_out=0x32768.
  - 0xFFFF → sign=1, bcd_out=0x00001.
  - 0x7FFF → sign=0, bcd_out=0x32767.
- Handshake:
  - Hold start high continuously → one done every 18 cycles.
  - Pulse start on cycle 3 of a conversion → ignored; result unchanged; no extra done.
- Reset mid-conversion: drive reset_n low for one edge at shift 5 → all outputs 0 on the next cycle and no done follows. A new start of 255 then yields bcd_out=0x00255.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Start/done handshake and result bus for bin2bcd_seq; the requester uses master, the converter uses slave.
// Parameters must match the bin2bcd_seq instance attached to the slave modport.
interface bin2bcd_seq_if #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
);
  logic                   start;
  logic [BIN_WIDTH-1:0]   bin_in;
  logic                   busy;
  logic                   done;
  logic [4*DIGITS-1:0]    bcd_out;
  logic                   overflow;
  logic                   sign;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow, sign
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow, sign
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter; signed operands when BIN2BCD_SEQ_SIGNED_EN is defined.
// Latency BIN_WIDTH+1 cycles start-to-done; start is only sampled in IDLE, never queued.
module bin2bcd_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  bin2bcd_seq_if.slave bus
);

  localparam int CW = $clog2(BIN_WIDTH);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t               state, state_nxt;
  logic [BIN_WIDTH-1:0] sr;
  logic [BIN_WIDTH-1:0] load_mag;
  logic [BW-1:0]        wd;
  logic [BW-1:0]        wd_adj;
  logic [CW-1:0]        cnt;
  logic                 ovf_sticky;
  logic                 done_q;
  logic [BW-1:0]        bcd_q;
  logic                 ovf_q;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(BIN_WIDTH - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction for every digit at or above 5, ahead of the shift.
  always_comb begin
    wd_adj = wd;
    for (int i = 0; i < DIGITS; i++) begin
      if (wd[4*i +: 4] >= 4'd5) wd_adj[4*i +: 4] = wd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sr         <= '0;
      wd         <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == FINISH);
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr         <= load_mag;
            wd         <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
          end
        end
        SHIFT: begin
          // Bits leaving the top digit mean the value needs more than DIGITS digits.
          wd         <= {wd_adj[BW-2:0], sr[BIN_WIDTH-1]};
          sr         <= {sr[BIN_WIDTH-2:0], 1'b0};
          ovf_sticky <= ovf_sticky | wd_adj[BW-1];
          cnt        <= cnt + 1'b1;
        end
        FINISH: begin
          bcd_q <= wd;
          ovf_q <= ovf_sticky;
        end
        default: ;
      endcase
    end
  end

`ifdef BIN2BCD_SEQ_SIGNED_EN
  logic sign_cap;
  logic sign_q;

  // Two's-complement negate; the most negative value maps to 2^(BIN_WIDTH-1) as unsigned.
  assign load_mag = bus.bin_in[BIN_WIDTH-1] ? (~bus.bin_in + BIN_WIDTH'(1)) : bus.bin_in;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sign_cap <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) sign_cap <= bus.bin_in[BIN_WIDTH-1];
      if (state == FINISH)            sign_q   <= sign_cap;
    end
  end

  assign bus.sign = sign_q;
`else
  assign load_mag = bus.bin_in;
  assign bus.sign = 1'b0;
`endif

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule
